// File: rtl/fifo_uart_tx.sv
// Serial transmitter fed from a registered-read FIFO: pops one word, then sends
// start bit, DATA_WIDTH data bits LSB first and a stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [15:0]           frame_cnt
);
  // state | meaning
  // IDLE  | line idle, waiting for enable with a non-empty FIFO
  // POP   | FIFO read strobe cycle
  // LATCH | waiting for the registered FIFO read data
  // START | start bit (tx low)
  // DATA  | data bits, LSB first
  // STOP  | stop bit; at its end either pop the next word or go idle
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  tx_done_q, tx_done_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  pop_ok;
  logic                  bit_end;

  assign pop_ok  = enable && !fifo_empty;
  assign bit_end = (timer_q == TIMER_LAST);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    tx_done_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop_ok) state_d = POP;
      end
      POP: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d   = fifo_data;
        tx_d      = 1'b0;
        timer_d   = '0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d     = '0;
          tx_done_d   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          // Chaining straight into POP keeps the inter-frame gap at two cycles.
          state_d     = pop_ok ? POP : IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx         = tx_q;
  assign tx_done    = tx_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != IDLE);
  assign fifo_rd_cs = (state_q == POP);
  assign fifo_rd_en = (state_q == POP);

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per serial frame and width of the FIFO read data.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range is 2 or more.

Interface
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: permits a new FIFO pop when high.
REQ-006 SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-007 SHALL have port fifo_data, input, DATA_WIDTH bits: FIFO registered read data, valid 1 cycle after pop.
REQ-008 SHALL have port fifo_rd_cs, output, 1 bit: FIFO read chip select.
REQ-009 SHALL have port fifo_rd_en, output, 1 bit: FIFO read enable.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.
REQ-013 SHALL have port frame_cnt, output, 16 bits: count of completed frames.

Function
REQ-014 SHALL implement FSM states IDLE, POP, LATCH, START, DATA, STOP.
REQ-015 IDLE -> POP SHALL occur when enable=1 and fifo_empty=0 are sampled at an edge; otherwise the FSM SHALL stay in IDLE.
REQ-016 POP SHALL last exactly 1 cycle, with fifo_rd_cs=fifo_rd_en=1 in that cycle only; at all other times both SHALL be 0.
REQ-017 LATCH SHALL last 1 cycle; at its closing edge the shift register SHALL load fifo_data, tx SHALL go 0, and the FSM SHALL enter START.
REQ-018 With the pop condition sampled at edge k, tx SHALL fall at edge k+2.
REQ-019 START SHALL hold tx=0 for CLKS_PER_BIT cycles.
REQ-020 DATA SHALL send DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles.
REQ-021 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles.
REQ-022 A frame SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles long, from the falling edge of tx to the end of STOP.
REQ-023 The bit timer SHALL count 0..CLKS_PER_BIT-1 using $clog2(CLKS_PER_BIT) bits, and a bit counter SHALL count 0..DATA_WIDTH-1.
REQ-024 On STOP exit, tx_done SHALL pulse for 1 cycle and frame_cnt SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-025 On STOP exit, if enable=1 and fifo_empty=0, the FSM SHALL go directly to POP; otherwise it SHALL go to IDLE.
REQ-026 Back-to-back frames SHALL have falling edges of tx spaced exactly (DATA_WIDTH+2)*CLKS_PER_BIT+2 cycles apart; tx SHALL stay 1 during the POP and LATCH gap.
REQ-027 When enable deasserts mid-frame, the current frame SHALL complete unaltered and no further pop SHALL occur.
REQ-028 fifo_empty SHALL be ignored outside IDLE and STOP exit; the block SHALL never pop while fifo_empty=1.
REQ-029 The block SHALL pop exactly one entry per transmitted frame.
REQ-030 tx SHALL be driven from a flop, and fifo_rd_cs/fifo_rd_en SHALL be decoded only from the state register, so no output is combinational from inputs.

Reset
REQ-031 On rst=1 the FSM SHALL immediately (asynchronously) be in IDLE, with tx=1, busy=0, tx_done=0, fifo_rd_cs=fifo_rd_en=0, frame_cnt=0, and all counters and the shift register at 0.
REQ-032 Reset mid-frame SHALL abort the frame, return tx to 1 without waiting for clk, and not increment frame_cnt; the popped byte SHALL be discarded.
REQ-033 After rst deasserts, the first pop SHALL occur only after the IDLE entry condition is sampled.

Verification
REQ-034 Bench SHALL cover single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1 -> one pop; tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses once; frame_cnt=1.
REQ-035 Bench SHALL cover back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> 3 pops; tx falling edges 42 cycles apart; frame_cnt=3; no pop after fifo_empty=1.
REQ-036 Bench SHALL cover empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_rd_en never 1; tx=1; busy=0.
REQ-037 Bench SHALL cover enable drop: enable=0 during DATA of frame 1, 2 bytes queued -> frame 1 completes; second byte stays in FIFO; FSM returns to IDLE.
REQ-038 Bench SHALL cover reset mid-frame: rst pulsed during bit 3 of DATA -> tx=1 before the next clk edge; frame_cnt=0; busy=0.
REQ-039 Bench SHALL cover wrap: frame_cnt forced to 0xFFFF, one frame sent -> frame_cnt=0x0000 with a single tx_done pulse.
